seq_detect_n: RTL and testbench

SEQ_DETECT_N -- requirements
Module: seq_detect_n

---
 rtl/seq_detect_n_if.sv | 29 ++
 rtl/seq_detect_n.sv | 118 +++++++++++
 tb/tb_seq_detect_n.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/seq_detect_n_if.sv
// Bus bundle for seq_detect_n: serial bit stream, pattern load controls and
// the registered detection results. WIDTH and CNT_W must match the values
// given to the seq_detect_n instance that uses the slave side.
interface seq_detect_n_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    localparam int FILL_W = $clog2(WIDTH + 1);

    logic              x0;         // bit-valid strobe
    logic              x1;         // serial data bit
    logic              pat_load;   // capture pattern/overlap, restart detection
    logic [WIDTH-1:0]  pattern;    // pattern[WIDTH-1] is the first bit expected
    logic              overlap;    // 1 = overlapping matches
    logic              RG;         // registered match pulse
    logic              RN;         // registered reject pulse
    logic [FILL_W-1:0] fill;       // valid bits in the history window
    logic [CNT_W-1:0]  match_cnt;  // saturating match count

    modport master (
        output x0, x1, pat_load, pattern, overlap,
        input  RG, RN, fill, match_cnt
    );

    modport slave (
        input  x0, x1, pat_load, pattern, overlap,
        output RG, RN, fill, match_cnt
    );
endinterface

// File: rtl/seq_detect_n.sv
// seq_detect_n: serial N-bit pattern detector with overlapping or
// non-overlapping match modes, a fill counter and registered match/reject
// pulses. The saturating match counter is built only when the macro
// SEQ_DETECT_N_CNT_EN is defined; otherwise match_cnt reads constant 0.
module seq_detect_n #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic          clk,
    input  logic          reset,
    seq_detect_n_if.slave bus
);
    localparam int                FILL_W = $clog2(WIDTH + 1);
    localparam logic [FILL_W-1:0] FULL   = FILL_W'(WIDTH);

    // Elaboration-time guard on the supported parameter ranges.
    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
        $error("seq_detect_n: WIDTH must be in 2..16");
    end
    if (CNT_W < 1 || CNT_W > 16) begin : g_bad_cnt_w
        $error("seq_detect_n: CNT_W must be in 1..16");
    end

    logic [WIDTH-1:0]  history;
    logic [FILL_W-1:0] fill_q;
    logic [WIDTH-1:0]  shadow_pat;
    logic              shadow_ov;
    logic              rg_q;
    logic              rn_q;

    logic [WIDTH-1:0]  hist_next;
    logic [FILL_W-1:0] fill_inc;
    logic              accept;
    logic              window_full;
    logic              hit;
    logic              miss;

    // Next-window evaluation for the bit presented on this edge.
    always_comb begin
        // NOTE: every signal driven here is assigned unconditionally, so no latch can be inferred.
        accept      = bus.x0 & ~bus.pat_load;
        hist_next   = {history[WIDTH-2:0], bus.x1};
        fill_inc    = (fill_q == FULL) ? FULL : fill_q + FILL_W'(1);
        window_full = (fill_inc == FULL);
        hit         = accept & window_full & (hist_next == shadow_pat);
        miss        = accept & window_full & ~(hist_next == shadow_pat);
    end

    // Shadow pattern/overlap capture; only a load can change them.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: reset is asynchronous and clears the shadows too, so pattern 0 is live until the first load.
        if (!reset) begin
            shadow_pat <= '0;
            shadow_ov  <= 1'b0;
        end else if (bus.pat_load) begin
            // NOTE: sequential state uses non-blocking assignment so all registers see pre-edge values.
            shadow_pat <= bus.pattern;
            shadow_ov  <= bus.overlap;
        end
    end

    // History shift register and fill counter; gaps (x0=0) hold both.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            history <= '0;
            fill_q  <= '0;
        end else if (bus.pat_load) begin
            history <= '0;
            fill_q  <= '0;
        end else if (accept) begin
            history <= hist_next;
            // A non-overlapping match consumes the window; an overlapping
            // one keeps it full so the very next bit is checked again.
            if (hit && !shadow_ov) begin
                fill_q <= '0;
            end else begin
                fill_q <= fill_inc;
            end
        end
    end

    // One-cycle match/reject pulses; a load or an idle edge clears both.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rg_q <= 1'b0;
            rn_q <= 1'b0;
        end else begin
            rg_q <= hit;
            rn_q <= miss;
        end
    end

`ifdef SEQ_DETECT_N_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;

    // Saturating match counter, restarted by every load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (bus.pat_load) begin
            cnt_q <= '0;
        end else if (hit && cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.match_cnt = cnt_q;
`else
    assign bus.match_cnt = '0;
`endif

    assign bus.RG   = rg_q;
    assign bus.RN   = rn_q;
    assign bus.fill = fill_q;

endmodule

// File: tb/tb_seq_detect_n.sv
// Self-checking bench for seq_detect_n (WIDTH=4, CNT_W=2). The reference
// model keeps the accepted bits since the last restart in a queue and
// decides matches by comparing the newest WIDTH bits with the loaded pattern.
module tb_seq_detect_n;
    localparam int WIDTH  = 4;
    localparam int CNT_W  = 2;
    localparam int CNT_MX = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    seq_detect_n_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    seq_detect_n #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state.
    bit q[$];
    int m_pat;
    bit m_ov;
    int m_cnt;
    bit m_rg;
    bit m_rn;

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int exp_cnt();
`ifdef SEQ_DETECT_N_CNT_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    function automatic int window_value();
        int w = 0;
        for (int i = 0; i < q.size(); i++) w = (w << 1) | int'(q[i]);
        return w;
    endfunction

    task automatic model_reset();
        q.delete();
        m_pat = 0;
        m_ov  = 1'b0;
        m_cnt = 0;
        m_rg  = 1'b0;
        m_rn  = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ":RG"},   int'(bus.RG),        int'(m_rg));
        check({tag, ":RN"},   int'(bus.RN),        int'(m_rn));
        check({tag, ":fill"}, int'(bus.fill),      q.size());
        check({tag, ":cnt"},  int'(bus.match_cnt), exp_cnt());
    endtask

    // Present one edge's worth of inputs, advance model, compare #1 after the edge.
    task automatic step(input string tag, input bit v, input bit d, input bit ld,
                        input int pat, input bit ov);
        bus.x0       = v;
        bus.x1       = d;
        bus.pat_load = ld;
        bus.pattern  = pat[WIDTH-1:0];
        bus.overlap  = ov;
        @(posedge clk);
        #1;
        m_rg = 1'b0;
        m_rn = 1'b0;
        if (ld) begin
            m_pat = pat & ((1 << WIDTH) - 1);
            m_ov  = ov;
            q.delete();
            m_cnt = 0;
        end else if (v) begin
            q.push_back(d);
            if (q.size() > WIDTH) void'(q.pop_front());
            if (q.size() == WIDTH) begin
                if (window_value() == m_pat) begin
                    m_rg = 1'b1;
                    if (m_cnt < CNT_MX) m_cnt++;
                    if (!m_ov) q.delete();
                end else begin
                    m_rn = 1'b1;
                end
            end
        end
        check_outputs(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'($urandom_range(0, 1)), 1'b0, int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    endtask

    task automatic send_bits(input string tag, input int bits[]);
        foreach (bits[i]) step(tag, 1'b1, 1'(bits[i]), 1'b0, 0, 1'b0);
    endtask

    initial begin
        int stream7[] = '{1, 0, 1, 1, 0, 1, 1};
        bus.x0 = 1'b0; bus.x1 = 1'b0; bus.pat_load = 1'b0;
        bus.pattern = '0; bus.overlap = 1'b0;
        model_reset();

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        reset = 1'b1;

        // Overlapping 1011: matches after bits 4 and 7, rejects after 5 and 6.
        step("load_ov", 1'b0, 1'b0, 1'b1, 'b1011, 1'b1);
        send_bits("ov_stream", stream7);
        idle("ov_idle");

        // Same stream, non-overlapping.
        step("load_nov", 1'b0, 1'b0, 1'b1, 'b1011, 1'b0);
        send_bits("nov_stream", stream7);

        // Gap of 5 idle edges before the final bit.
        step("load_gap", 1'b0, 1'b0, 1'b1, 'b1011, 1'b1);
        send_bits("gap_head", '{1, 0, 1});
        repeat (5) idle("gap_idle");
        send_bits("gap_tail", '{1});

        // Load and a valid bit on the same edge: the bit is dropped.
        step("load_drop", 1'b1, 1'b1, 1'b1, 'b1011, 1'b1);
        send_bits("after_drop", '{0, 1, 1});

        // Counter saturation with 1111 overlapping.
        step("load_sat", 1'b0, 1'b0, 1'b1, 'b1111, 1'b1);
        send_bits("sat", '{1, 1, 1, 1, 1, 1, 1, 1});

        // Asynchronous reset between edges with fill=3.
        step("load_ar", 1'b0, 1'b0, 1'b1, 'b1011, 1'b1);
        send_bits("ar_fill", '{1, 0, 1});
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(posedge clk);
        #1 reset = 1'b1;
        check_outputs("rst_held");
        send_bits("zero_pat", '{0, 0, 0, 0, 0});

        // Randomised traffic, including pattern/overlap churn between loads.
        for (int i = 0; i < 600; i++) begin
            bit ld  = ($urandom_range(0, 24) == 0);
            bit v   = ($urandom_range(0, 3) != 0);
            bit d   = 1'($urandom_range(0, 1));
            int pat = int'($urandom_range(0, 15));
            bit ov  = 1'($urandom_range(0, 1));
            step("rand", v, d, ld, pat, ov);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
